// File: rtl/vx_cache_core_req_dispatch_pkg.sv
// Shared types and elaboration helpers for the core request dispatcher.
package vx_cache_core_req_dispatch_pkg;

   // Index width that never collapses to zero bits.
   function automatic int unsigned log2up(int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Word address width for a 32-bit byte address space.
   function automatic int unsigned word_addr_width(int unsigned word_size);
      return 32 - $clog2(word_size);
   endfunction

   function automatic bit is_pow2(int unsigned n);
      return (n != 0) && ((n & (n - 1)) == 0);
   endfunction

   // Batch tracking: first cycle of a batch versus continuation cycles.
   typedef enum logic {
      DISP_FIRST = 1'b0,
      DISP_CONT  = 1'b1
   } disp_state_e;

   localparam int unsigned PERF_WIDTH = 32;

endpackage

// File: rtl/vx_cache_core_req_dispatch_if.sv
// Core batch request port plus per-bank output slots with valid/ready.
interface vx_cache_core_req_dispatch_if
   import vx_cache_core_req_dispatch_pkg::*;
#(
   parameter int unsigned NUM_BANKS       = 4,
   parameter int unsigned NUM_REQUESTS    = 4,
   parameter int unsigned TAG_WIDTH       = 8,
   parameter int unsigned WORD_ADDR_WIDTH = 30,
   parameter int unsigned TID_WIDTH       = log2up(NUM_REQUESTS)
);
   logic [NUM_REQUESTS-1:0]                 core_req_valid;
   logic [NUM_REQUESTS*WORD_ADDR_WIDTH-1:0] core_req_addr;
   logic [TAG_WIDTH-1:0]                    core_req_tag;
   logic                                    core_req_ready;

   logic [NUM_BANKS-1:0]                    bank_req_valid;
   logic [NUM_BANKS*TID_WIDTH-1:0]          bank_req_tid;
   logic [NUM_BANKS*WORD_ADDR_WIDTH-1:0]    bank_req_addr;
   logic [NUM_BANKS*TAG_WIDTH-1:0]          bank_req_tag;
   logic [NUM_BANKS-1:0]                    bank_req_ready;

   // Environment side: the core and the bank queues.
   modport master (
      output core_req_valid, core_req_addr, core_req_tag, bank_req_ready,
      input  core_req_ready, bank_req_valid, bank_req_tid, bank_req_addr, bank_req_tag
   );

   // Dispatcher side.
   modport slave (
      input  core_req_valid, core_req_addr, core_req_tag, bank_req_ready,
      output core_req_ready, bank_req_valid, bank_req_tid, bank_req_addr, bank_req_tag
   );
endinterface

// File: rtl/vx_cache_core_req_dispatch_priority_encoder.sv
// Lowest-set-bit index of an N-bit vector, with an any-bit-set flag.
module vx_cache_core_req_dispatch_priority_encoder
   import vx_cache_core_req_dispatch_pkg::*;
#(
   parameter int unsigned N = 4,
   parameter int unsigned W = log2up(N)
) (
   input  logic [N-1:0] data_in,
   output logic [W-1:0] index,
   output logic         valid_out
);

   // Scan upward; the first set bit wins.
   always_comb begin
      index     = '0;
      valid_out = 1'b0;
      for (int unsigned i = 0; i < N; i++) begin
         if (data_in[i] && !valid_out) begin
            index     = W'(i);
            valid_out = 1'b1;
         end
      end
   end

endmodule

// File: rtl/vx_cache_core_req_dispatch.sv
// Routes a batch of per-thread word requests to per-bank registered slots,
// serialising bank conflicts in ascending thread order.
module vx_cache_core_req_dispatch
   import vx_cache_core_req_dispatch_pkg::*;
#(
   parameter int unsigned BANK_LINE_SIZE = 16,
   parameter int unsigned WORD_SIZE      = 4,
   parameter int unsigned NUM_BANKS      = 4,
   parameter int unsigned NUM_REQUESTS   = 4,
   parameter int unsigned SPLIT_CAPABLE  = 0,
   parameter int unsigned TAG_WIDTH      = 8
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    split_en,
   vx_cache_core_req_dispatch_if.slave req_if,
   output logic [PERF_WIDTH-1:0]   perf_conflicts
);

   localparam int unsigned WORD_ADDR_WIDTH = word_addr_width(WORD_SIZE);
   localparam int unsigned REQS_BITS       = log2up(NUM_REQUESTS);
   localparam int unsigned BANK_IDX_W      = log2up(NUM_BANKS);
   localparam int unsigned BANK_OFF        = $clog2(BANK_LINE_SIZE / WORD_SIZE);
   localparam int unsigned SPLIT_RATIO     = (NUM_BANKS >= NUM_REQUESTS) ? (NUM_BANKS / NUM_REQUESTS) : 1;
   localparam int unsigned SPLIT_BITS      = $clog2(SPLIT_RATIO);
   localparam logic [BANK_IDX_W-1:0] BANK_MASK  = BANK_IDX_W'(NUM_BANKS - 1);
   localparam logic [BANK_IDX_W-1:0] SPLIT_MASK = BANK_IDX_W'(SPLIT_RATIO - 1);

   if (!is_pow2(NUM_BANKS)) begin : g_chk_banks
      $error("NUM_BANKS must be a power of 2");
   end
   if (!is_pow2(NUM_REQUESTS)) begin : g_chk_reqs
      $error("NUM_REQUESTS must be a power of 2");
   end
   if ((SPLIT_CAPABLE != 0) && ((NUM_BANKS < NUM_REQUESTS) || ((NUM_BANKS % NUM_REQUESTS) != 0))) begin : g_chk_split
      $error("SPLIT_CAPABLE requires NUM_BANKS to be a multiple of NUM_REQUESTS");
   end

   logic [NUM_REQUESTS-1:0][WORD_ADDR_WIDTH-1:0] core_addr;
   logic [NUM_REQUESTS-1:0][BANK_IDX_W-1:0]      bank_idx;
   logic [NUM_REQUESTS-1:0]                      pend;
   logic [NUM_REQUESTS-1:0]                      picked;
   logic [NUM_REQUESTS-1:0]                      sent_r;
   logic [NUM_BANKS-1:0][NUM_REQUESTS-1:0]       bank_reqs;
   logic [NUM_BANKS-1:0][REQS_BITS-1:0]          sel_tid;
   logic [NUM_BANKS-1:0]                         sel_valid;
   logic [NUM_BANKS-1:0]                         slot_free;
   logic [NUM_BANKS-1:0]                         pick;
   logic                                         batch_ready;

   logic [NUM_BANKS-1:0]                         valid_r;
   logic [NUM_BANKS-1:0][REQS_BITS-1:0]          tid_r;
   logic [NUM_BANKS-1:0][WORD_ADDR_WIDTH-1:0]    addr_r;
   logic [NUM_BANKS-1:0][TAG_WIDTH-1:0]          tag_r;

   disp_state_e state_q, state_d;
   logic        perf_inc;

   assign core_addr = req_if.core_req_addr;
   assign pend      = req_if.core_req_valid & ~sent_r;
   assign slot_free = ~valid_r | req_if.bank_req_ready;

   // Bank index per thread; the masks make the single-bank case resolve to 0.
   always_comb begin
      bank_idx = '0;
      for (int unsigned i = 0; i < NUM_REQUESTS; i++) begin
         if ((SPLIT_CAPABLE != 0) && split_en)
            bank_idx[i] = (BANK_IDX_W'(i) << SPLIT_BITS)
                        | (BANK_IDX_W'(core_addr[i] >> BANK_OFF) & SPLIT_MASK);
         else
            bank_idx[i] = BANK_IDX_W'(core_addr[i] >> BANK_OFF) & BANK_MASK;
      end
   end

   // Per-bank view of which pending threads target that bank.
   always_comb begin
      bank_reqs = '0;
      for (int unsigned b = 0; b < NUM_BANKS; b++)
         for (int unsigned i = 0; i < NUM_REQUESTS; i++)
            bank_reqs[b][i] = pend[i] && (bank_idx[i] == BANK_IDX_W'(b));
   end

   for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
      vx_cache_core_req_dispatch_priority_encoder #(
         .N (NUM_REQUESTS)
      ) u_enc (
         .data_in   (bank_reqs[b]),
         .index     (sel_tid[b]),
         .valid_out (sel_valid[b])
      );
   end

   assign pick = sel_valid & slot_free;

   // Threads consumed by this cycle's picks.
   always_comb begin
      picked = '0;
      for (int unsigned b = 0; b < NUM_BANKS; b++)
         if (pick[b]) picked[sel_tid[b]] = 1'b1;
   end

   assign batch_ready         = ~|(pend & ~picked);
   assign req_if.core_req_ready = batch_ready;

   // Output slots: refill when free, otherwise hold.
   always_ff @(posedge clk) begin
      if (reset) begin
         valid_r <= '0;
         tid_r   <= '0;
         addr_r  <= '0;
         tag_r   <= '0;
      end else begin
         for (int unsigned b = 0; b < NUM_BANKS; b++) begin
            if (slot_free[b]) begin
               valid_r[b] <= pick[b];
               if (pick[b]) begin
                  tid_r[b]  <= sel_tid[b];
                  addr_r[b] <= core_addr[sel_tid[b]];
                  tag_r[b]  <= req_if.core_req_tag;
               end
            end
         end
      end
   end

   // Record dispatched threads until the batch completes.
   always_ff @(posedge clk) begin
      if (reset)            sent_r <= '0;
      else if (batch_ready) sent_r <= '0;
      else                  sent_r <= sent_r | picked;
   end

   // Batch state register.
   always_ff @(posedge clk) begin
      if (reset) state_q <= DISP_FIRST;
      else       state_q <= state_d;
   end

   // A batch that misses ready in its first cycle is a conflict batch.
   always_comb begin
      state_d  = state_q;
      perf_inc = 1'b0;
      case (state_q)
         DISP_FIRST: begin
            if ((|req_if.core_req_valid) && !batch_ready) begin
               state_d  = DISP_CONT;
               perf_inc = 1'b1;
            end
         end
         DISP_CONT: begin
            if (batch_ready) state_d = DISP_FIRST;
         end
         default: state_d = DISP_FIRST;
      endcase
   end

   // Saturating conflict counter.
   always_ff @(posedge clk) begin
      if (reset)
         perf_conflicts <= '0;
      else if (perf_inc && (perf_conflicts != '1))
         perf_conflicts <= perf_conflicts + 1'b1;
   end

   assign req_if.bank_req_valid = valid_r;
   assign req_if.bank_req_tid   = tid_r;
   assign req_if.bank_req_addr  = addr_r;
   assign req_if.bank_req_tag   = tag_r;

endmodule
